// File: rtl/me_pkg.sv
// Types and widths shared by the motion-estimation blocks: result field widths,
// frame SAD width and the macroblock scheduler state encoding.
package me_pkg;

  localparam int MVEC_W      = 12;
  localparam int SAD_W       = 16;
  localparam int POS_W       = 6;
  localparam int RES_W       = 40;
  localparam int FRAME_SAD_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_CHECK         = 3'd1,
    ST_REQ           = 3'd2,
    ST_WAIT_ACK_FALL = 3'd3,
    ST_ADVANCE       = 3'd4,
    ST_DRAIN         = 3'd5,
    ST_DONE          = 3'd6
  } sched_state_e;

endpackage

// File: rtl/mb_result_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally. Pops on an empty FIFO are ignored.
module mb_result_fifo #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_pop;

  assign valid     = (count != '0);
  assign do_pop    = pop && valid;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mb_scheduler.sv
// Frame scheduler: walks macroblocks in raster order, runs a 4-phase req/ack
// handshake per block, queues tagged results and keeps a saturating frame SAD.
module mb_scheduler
  import me_pkg::*;
#(
  parameter int MB_COLS    = 8,
  parameter int MB_ROWS    = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [5:0]  mb_x,
  output logic [5:0]  mb_y,
  output logic        req_c,
  input  logic        ack_c,
  input  logic [11:0] mvec_c,
  input  logic [15:0] sad_c,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [39:0] res_data,
  output logic [23:0] frame_sad
);

  localparam int                CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [POS_W-1:0]  LAST_X = POS_W'(MB_COLS - 1);
  localparam logic [POS_W-1:0]  LAST_Y = POS_W'(MB_ROWS - 1);

  sched_state_e      state;
  sched_state_e      state_nxt;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_push;
  logic              fifo_pop;
  logic              has_space;
  logic              last_x;
  logic              last_mb;
  logic [RES_W-1:0]  push_data;

  function automatic logic [FRAME_SAD_W-1:0] sat_add(
    input logic [FRAME_SAD_W-1:0] acc,
    input logic [SAD_W-1:0]       inc
  );
    logic [FRAME_SAD_W:0] sum;
    sum = {1'b0, acc} + {{(FRAME_SAD_W + 1 - SAD_W){1'b0}}, inc};
    return sum[FRAME_SAD_W] ? {FRAME_SAD_W{1'b1}} : sum[FRAME_SAD_W-1:0];
  endfunction

  assign has_space = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign last_x    = (mb_x == LAST_X);
  assign last_mb   = last_x && (mb_y == LAST_Y);
  assign fifo_push = (state == ST_REQ) && ack_c;
  assign fifo_pop  = res_valid && res_ready;
  assign push_data = {mb_y, mb_x, mvec_c, sad_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:          if (start)     state_nxt = ST_CHECK;
      ST_CHECK:         if (has_space) state_nxt = ST_REQ;
      ST_REQ:           if (ack_c)     state_nxt = ST_WAIT_ACK_FALL;
      ST_WAIT_ACK_FALL: if (!ack_c)    state_nxt = ST_ADVANCE;
      ST_ADVANCE:       state_nxt = last_mb ? ST_DRAIN : ST_CHECK;
      ST_DRAIN:         if (fifo_count == '0) state_nxt = ST_DONE;
      ST_DONE:          state_nxt = ST_IDLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs so req_c and the coordinates never glitch on decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_c     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mb_x      <= '0;
      mb_y      <= '0;
      frame_sad <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mb_x      <= '0;
            mb_y      <= '0;
            frame_sad <= '0;
            busy      <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (has_space)
            req_c <= 1'b1;
        end
        ST_REQ: begin
          if (ack_c) begin
            req_c     <= 1'b0;
            frame_sad <= sat_add(frame_sad, sad_c);
          end
        end
        ST_ADVANCE: begin
          if (!last_mb) begin
            if (last_x) begin
              mb_x <= '0;
              mb_y <= mb_y + POS_W'(1);
            end else begin
              mb_x <= mb_x + POS_W'(1);
            end
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  mb_result_fifo #(
    .DATA_W (RES_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head_data (res_data),
    .valid     (res_valid),
    .count     (fifo_count)
  );

endmodule
